// File: rtl/poly_operand_feeder_pkg.sv
// Shared types and constants for the polynomial operand feeder: state encoding,
// operand slot indices and the data width.
package poly_operand_feeder_pkg;

  localparam int DATA_W  = 8;
  localparam int NUM_OPS = 4;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [1:0]        op_idx_t;

  // Operands are streamed to the evaluator in this order.
  localparam op_idx_t IDX_A = 2'd0;
  localparam op_idx_t IDX_B = 2'd1;
  localparam op_idx_t IDX_C = 2'd2;
  localparam op_idx_t IDX_X = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRIVE_LO = 3'd1,
    ST_DRIVE_HI = 3'd2,
    ST_EVAL     = 3'd3,
    ST_HOLD     = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/poly_operand_feeder_if.sv
// Bundle of the operand input, evaluator-facing and result signals of the feeder.
// slave = feeder side, master = environment side (producer, evaluator, consumer).
interface poly_operand_feeder_if;
  import poly_operand_feeder_pkg::*;

  // Operand set: transfer on a rising edge with in_valid && in_ready.
  // Result: transfer on a rising edge with res_valid && res_ready; res_valid holds until then.
  logic  in_valid;
  logic  in_ready;
  data_t in_a;
  data_t in_b;
  data_t in_c;
  data_t in_x;

  data_t ev_data_in;
  logic  ev_go;
  data_t ev_result;

  logic  res_valid;
  logic  res_ready;
  data_t res_data;

  logic  busy;

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_x, ev_result, res_ready,
    output in_ready, ev_data_in, ev_go, res_valid, res_data, busy
  );

  modport master (
    output in_valid, in_a, in_b, in_c, in_x, ev_result, res_ready,
    input  in_ready, ev_data_in, ev_go, res_valid, res_data, busy
  );

endinterface

// File: rtl/poly_operand_feeder_phase_counter.sv
// Loadable down-counter with a zero flag; times the low, high and eval phases.
module poly_operand_feeder_phase_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  // Load wins over decrement; decrement saturates at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count = cnt_q;
  assign zero  = (cnt_q == '0);

endmodule

// File: rtl/poly_operand_feeder.sv
// Latches an A/B/C/x operand set, strobes it word by word into a polynomial
// evaluator, waits out the evaluator latency and holds the captured result.
module poly_operand_feeder
  import poly_operand_feeder_pkg::*;
#(
  parameter int GO_LOW_CYCLES  = 2,
  parameter int GO_HIGH_CYCLES = 2,
  parameter int EVAL_LATENCY   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 ev_resetn,
  output state_e               dbg_state,
  poly_operand_feeder_if.slave bus
);

  localparam int CNT_MAX = max3(GO_LOW_CYCLES, GO_HIGH_CYCLES, EVAL_LATENCY);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Each phase loads N-1 and leaves on the cycle the counter reads zero: N cycles total.
  localparam logic [CNT_W-1:0] LO_LOAD   = CNT_W'(GO_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HI_LOAD   = CNT_W'(GO_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_LATENCY - 1);

  state_e  state_d, state_q;
  op_idx_t idx_d, idx_q;
  data_t   ops_d [NUM_OPS];
  data_t   ops_q [NUM_OPS];
  data_t   res_data_d, res_data_q;
  data_t   ev_data_d, ev_data_q;
  logic    ev_go_d, ev_go_q;
  logic    res_valid_d, res_valid_q;
  logic    busy_d, busy_q;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_value;
  logic             cnt_zero;

  poly_operand_feeder_phase_counter #(
    .W (CNT_W)
  ) u_phase_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_value),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    ops_d        = ops_q;
    res_data_d   = res_data_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          ops_d[IDX_A] = bus.in_a;
          ops_d[IDX_B] = bus.in_b;
          ops_d[IDX_C] = bus.in_c;
          ops_d[IDX_X] = bus.in_x;
          idx_d        = IDX_A;
          state_d      = ST_DRIVE_LO;
          cnt_load     = 1'b1;
          cnt_load_val = LO_LOAD;
        end
      end
      ST_DRIVE_LO: begin
        if (cnt_zero) begin
          state_d      = ST_DRIVE_HI;
          cnt_load     = 1'b1;
          cnt_load_val = HI_LOAD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DRIVE_HI: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          if (idx_q == IDX_X) begin
            state_d      = ST_EVAL;
            cnt_load_val = EVAL_LOAD;
          end else begin
            idx_d        = idx_q + 2'd1;
            state_d      = ST_DRIVE_LO;
            cnt_load_val = LO_LOAD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_EVAL: begin
        if (cnt_zero) begin
          res_data_d = bus.ev_result;
          state_d    = ST_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (bus.res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from next-state so they line up with state_q.
    ev_go_d     = (state_d == ST_DRIVE_HI);
    ev_data_d   = ((state_d == ST_DRIVE_LO) || (state_d == ST_DRIVE_HI)) ? ops_d[idx_d] : '0;
    res_valid_d = (state_d == ST_HOLD);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= IDX_A;
      for (int i = 0; i < NUM_OPS; i++) begin
        ops_q[i] <= '0;
      end
      res_data_q  <= '0;
      ev_data_q   <= '0;
      ev_go_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ops_q       <= ops_d;
      res_data_q  <= res_data_d;
      ev_data_q   <= ev_data_d;
      ev_go_q     <= ev_go_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Evaluator shares our reset so an aborted set leaves no stale state behind.
  assign ev_resetn      = ~reset;
  assign dbg_state      = state_q;
  assign bus.in_ready   = (state_q == ST_IDLE);
  assign bus.ev_go      = ev_go_q;
  assign bus.ev_data_in = ev_data_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_poly_operand_feeder.sv
// Directed bench for poly_operand_feeder with a cycle-level evaluator model,
// an expected-result queue and an operand-order/strobe monitor.
module tb_poly_operand_feeder;
  import poly_operand_feeder_pkg::*;

  localparam int GL  = 2;
  localparam int GH  = 2;
  localparam int EL  = 8;
  localparam int LAT = 24;

  logic   clk;
  logic   reset;
  logic   ev_resetn;
  state_e dbg_state;

  poly_operand_feeder_if bus ();

  poly_operand_feeder #(
    .GO_LOW_CYCLES  (GL),
    .GO_HIGH_CYCLES (GH),
    .EVAL_LATENCY   (EL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ev_resetn (ev_resetn),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] poly(input logic [7:0] a, b, c, x);
    return a * x * x + b * x + c;
  endfunction

  // ---------------- evaluator model ----------------
  // Captures data_in on each go rise; result appears a few cycles after the 4th.
  logic       m_go_prev;
  logic [1:0] m_slot;
  logic [7:0] m_ops [4];
  int         m_wait;

  always @(posedge clk or negedge ev_resetn) begin
    if (!ev_resetn) begin
      m_go_prev     <= 1'b0;
      m_slot        <= 2'd0;
      m_wait        <= 0;
      bus.ev_result <= 8'h00;
      for (int i = 0; i < 4; i++) m_ops[i] <= 8'h00;
    end else begin
      m_go_prev <= bus.ev_go;
      if (bus.ev_go && !m_go_prev) begin
        m_ops[m_slot] <= bus.ev_data_in;
        m_slot        <= m_slot + 2'd1;
        if (m_slot == 2'd0) bus.ev_result <= 8'hA5;
        if (m_slot == 2'd3) m_wait <= 4;
      end
      if (m_wait > 0) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) bus.ev_result <= poly(m_ops[0], m_ops[1], m_ops[2], m_ops[3]);
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q [$];
  logic [7:0] op_q  [$];
  logic       go_prev, rv_prev;
  logic [7:0] data_prev;
  int         go_rises, hi_len, acc_cyc, rel_cyc;

  always @(negedge clk) begin
    if (reset) begin
      go_prev  = 1'b0;
      rv_prev  = 1'b0;
      go_rises = 0;
      hi_len   = 0;
      exp_q.delete();
      op_q.delete();
    end else begin
      check("busy_vs_ready", {31'd0, bus.busy}, {31'd0, !bus.in_ready});
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
      if (bus.ev_go && !go_prev) begin
        go_rises++;
        hi_len = 1;
        if (op_q.size() == 0) check("op_unexpected", 1, 0);
        else                  check("op_order", {24'd0, bus.ev_data_in}, {24'd0, op_q.pop_front()});
      end else if (bus.ev_go) begin
        hi_len++;
        check("go_data_stable", {24'd0, bus.ev_data_in}, {24'd0, data_prev});
      end
      if (!bus.ev_go && go_prev) check("go_high_len", hi_len, GH);
      if (dbg_state == ST_IDLE || dbg_state == ST_EVAL || dbg_state == ST_HOLD)
        check("ev_data_zero", {24'd0, bus.ev_data_in}, 0);
      if (bus.res_valid && !rv_prev) check("latency", cyc - acc_cyc, LAT);
      if (bus.res_valid && bus.res_ready) begin
        rel_cyc = cyc + 1;
        check("go_rises_per_set", go_rises, 4);
        go_rises = 0;
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else                   check("result", {24'd0, bus.res_data}, {24'd0, exp_q.pop_front()});
      end
      go_prev   = bus.ev_go;
      data_prev = bus.ev_data_in;
      rv_prev   = bus.res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, b, c, x, input logic [7:0] exp, input bit keep_valid);
    int n;
    @(posedge clk); #1;
    bus.in_a = a; bus.in_b = b; bus.in_c = c; bus.in_x = x;
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(exp);
      op_q.push_back(a); op_q.push_back(b); op_q.push_back(c); op_q.push_back(x);
      @(posedge clk); #1;
      if (!keep_valid) bus.in_valid = 1'b0;
      @(negedge clk);
      check("busy_after_accept", {31'd0, bus.busy}, 1);
      check("in_ready_after_accept", {31'd0, bus.in_ready}, 0);
    end
  endtask

  task automatic drain(input logic [7:0] last);
    int n;
    n = 0;
    @(negedge clk); #1;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    @(negedge clk);
    check("res_valid_after_release", {31'd0, bus.res_valid}, 0);
    check("res_data_retained", {24'd0, bus.res_data}, {24'd0, last});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.res_ready = 1'b1;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_x = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, bus.in_ready}, 1);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_ev_go", {31'd0, bus.ev_go}, 0);
    check("rst_ev_data", {24'd0, bus.ev_data_in}, 0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 0);
    check("rst_res_data", {24'd0, bus.res_data}, 0);
    check("rst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("rst_ev_resetn", {31'd0, ev_resetn}, 0);
    #1 reset = 1'b0;

    // Basic evaluation and mod-256 wrap.
    send(8'd1, 8'd2, 8'd3, 8'd4, 8'h1B, 1'b0);
    drain(8'h1B);
    send(8'd16, 8'd0, 8'd0, 8'd4, 8'h00, 1'b0);
    drain(8'h00);
    send(8'd0, 8'd0, 8'd5, 8'd9, 8'h05, 1'b0);
    drain(8'h05);

    // Consumer stalls in HOLD while a producer keeps offering.
    bus.res_ready = 1'b0;
    send(8'd1, 8'd2, 8'd3, 8'd4, 8'h1B, 1'b1);
    n = 0;
    while (!bus.res_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("hold_reached", {31'd0, bus.res_valid}, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_res_valid", {31'd0, bus.res_valid}, 1);
      check("hold_res_data", {24'd0, bus.res_data}, 8'h1B);
      check("hold_in_ready", {31'd0, bus.in_ready}, 0);
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    drain(8'h1B);

    // Reset during the high phase of operand C.
    send(8'd1, 8'd2, 8'd3, 8'd4, 8'h1B, 1'b0);
    n = 0;
    @(negedge clk); #1;
    while (!(go_rises == 3 && bus.ev_go) && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    check("reached_c_high", go_rises, 3);
    reset = 1'b1;
    #1;
    check("midrst_ev_go", {31'd0, bus.ev_go}, 0);
    check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
    check("midrst_in_ready", {31'd0, bus.in_ready}, 1);
    check("midrst_res_valid", {31'd0, bus.res_valid}, 0);
    check("midrst_ev_data", {24'd0, bus.ev_data_in}, 0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    send(8'd2, 8'd1, 8'd1, 8'd3, 8'h16, 1'b0);
    drain(8'h16);

    // Back-to-back sets: second accept on the cycle after the first release.
    send(8'd1, 8'd2, 8'd3, 8'd4, 8'h1B, 1'b0);
    send(8'd0, 8'd0, 8'd5, 8'd9, 8'h05, 1'b0);
    check("b2b_accept_gap", acc_cyc - rel_cyc, 1);
    drain(8'h05);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
